// File: rtl/reg_delay_line.sv
// reg_delay_line: parametrised register delay line with per-stage valid bits,
// stall (Enable low), synchronous flush (Clear) and a selectable tap.
//
// Valid semantics: In_Valid qualifies Reg_In on every edge where Enable=1 and
// Clear=0. The word is captured whatever In_Valid is, and the valid bit travels
// with it. There is no ready/back-pressure: the producer owns Enable.
module reg_delay_line #(
  parameter int              WIDTH     = 4,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Enable,
  input  logic                       Clear,
  input  logic [WIDTH-1:0]           Reg_In,
  input  logic                       In_Valid,
  input  logic [$clog2(DEPTH)-1:0]   Tap_Sel,
  output logic [WIDTH-1:0]           Reg_Out,
  output logic                       Out_Valid,
  output logic [WIDTH-1:0]           Tap_Out,
  output logic                       Tap_Valid,
  output logic [$clog2(DEPTH+1)-1:0] Fill_Count
);

  localparam int SW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] v;
  logic [CW-1:0]    count;
  logic             grow;
  logic             shrink;

  // A valid word entering while none leaves grows the count, and the reverse shrinks it.
  // The two cases are exclusive, so the count cannot pass DEPTH or go below 0.
  assign grow   = In_Valid & ~v[DEPTH-1];
  assign shrink = ~In_Valid & v[DEPTH-1];

  // Stage registers, valid bits and fill count; priority Reset > Clear > Enable > hold.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= RESET_VAL;
      v     <= '0;
      count <= '0;
    end else if (Clear) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= RESET_VAL;
      v     <= '0;
      count <= '0;
    end else if (Enable) begin
      stage[0] <= Reg_In;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      v <= {v[DEPTH-2:0], In_Valid};
      if (grow) begin
        count <= count + CW'(1);
      end else if (shrink) begin
        count <= count - CW'(1);
      end
    end
  end

  // Final stage is read straight from registers.
  assign Reg_Out    = stage[DEPTH-1];
  assign Out_Valid  = v[DEPTH-1];
  assign Fill_Count = count;

  // Tap mux; an out-of-range select (non power-of-2 DEPTH) falls back to the last stage.
  always_comb begin
    Tap_Out   = stage[DEPTH-1];
    Tap_Valid = v[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (Tap_Sel == SW'(k)) begin
        Tap_Out   = stage[k];
        Tap_Valid = v[k];
      end
    end
  end

endmodule

// File: doc/reg_delay_line.md
Name: reg_delay_line

Overview:
Parametrised multi-stage register pipeline (delay line) with per-stage valid tracking, stall, synchronous flush and a selectable intermediate tap. It is the generalised successor of the fixed 4-bit, 4-stage register chain. Datapath blocks use it to align data streams with differing latencies. Fixed-depth register chains in the datapath are to be replaced by this block.

Parameters:
WIDTH, 4, data width in bits (>=1)
DEPTH, 4, number of register stages (>=2)
RESET_VAL, 0, value loaded into every data stage on Reset and Clear

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Enable  input  1  advance pipeline when 1; hold all stages when 0
Clear  input  1  synchronous flush; priority over Enable
Reg_In  input  WIDTH  data into stage 0
In_Valid  input  1  qualifies Reg_In
Tap_Sel  input  $clog2(DEPTH)  stage index driven on Tap_Out
Reg_Out  output  WIDTH  data of stage DEPTH-1
Out_Valid  output  1  valid bit of stage DEPTH-1
Tap_Out  output  WIDTH  data of stage Tap_Sel
Tap_Valid  output  1  valid bit of stage Tap_Sel
Fill_Count  output  $clog2(DEPTH+1)  number of stages whose valid bit is 1

Behaviour:
- One clock domain: Clock. Reset is asynchronous and active-high. No other asynchronous inputs.
- Storage: DEPTH data registers, stage[0..DEPTH-1], plus DEPTH valid bits, v[0..DEPTH-1].
- Reset asserted: every stage = RESET_VAL and every v = 0, immediately, without waiting for a clock edge. Therefore Reg_Out = Tap_Out = RESET_VAL, Out_Valid = Tap_Valid = 0 and Fill_Count = 0 while Reset is high.
- Priority at each rising edge: Reset, then Clear, then Enable, then hold.
- Clear=1: every stage = RESET_VAL and every v = 0. Enable and In_Valid are ignored on that edge.
- Enable=1 and Clear=0: stage[0] <= Reg_In and v[0] <= In_Valid. For k>0, stage[k] <= stage[k-1] and v[k] <= v[k-1].
- Data is captured regardless of In_Valid. A bubble (In_Valid=0) still shifts and carries v=0.
- Enable=0 and Clear=0: all stages and valid bits hold.
- Latency: a word presented with Enable=1 at edge N appears on Reg_Out after edge N+DEPTH-1, provided Enable stays 1 for all intervening edges. Each Enable=0 cycle adds one cycle of latency.
- Reg_Out and Out_Valid are taken directly from registers, with no combinational path from any input.
- Tap_Out and Tap_Valid are a combinational mux on Tap_Sel over the stage registers. Tap_Sel=k gives a delay of k+1 enabled edges.
- Tap_Sel >= DEPTH (possible when DEPTH is not a power of 2): select stage DEPTH-1.
- Fill_Count is a registered count equal to popcount(v), updated on the same edge as v. Next-count rules:
  - Clear: 0
  - Enable with In_Valid=1 and v[DEPTH-1]=0: +1
  - Enable with In_Valid=0 and v[DEPTH-1]=1: -1
  - otherwise: unchanged
- Fill_Count saturates naturally at DEPTH and never wraps.
- Reset asserted mid-stream discards all in-flight data. Reset released coincident with a Clock edge must not corrupt state: the first capture occurs on the next edge.
- Clear and Enable asserted together: the Clear result applies and the input word is dropped.

Test Plan:
1. Reset=1 for 2 cycles with Reg_In=4'hF -> Reg_Out=0, Tap_Out=0, Out_Valid=0, Fill_Count=0 before any clock edge. Assert Reset mid-cycle -> outputs go to 0 asynchronously.
2. WIDTH=4, DEPTH=4, Enable=1, In_Valid=1, Reg_In sequence B,9,3,6 on consecutive edges -> Reg_Out=B after the 4th edge, then 9, 3, 6. Out_Valid=1 from the 4th edge. Fill_Count steps 1,2,3,4 and holds at 4.
3. Tap check: Tap_Sel=1 with the same stream -> Tap_Out=B after the 2nd edge. Change Tap_Sel to 3 on the same cycle -> Tap_Out equals Reg_Out combinationally.
4. Stall: load A,5 and then drop Enable for 3 cycles -> all outputs and Fill_Count=2 unchanged. Raise Enable -> A reaches Reg_Out 3 cycles later than in the unstalled case.
5. Bubbles: In_Valid pattern 1,0,1,0 with data 1,2,3,4 -> Out_Valid pattern 1,0,1,0 from the 4th edge. Reg_Out still shows 1,2,3,4. Fill_Count peaks at 2.
6. Clear with pipeline full (Fill_Count=4) and Enable=1, Reg_In=7 -> next edge: all stages 0, Fill_Count=0, and 7 is never seen on Reg_Out. Repeat with DEPTH=5, Tap_Sel=7 -> Tap_Out follows stage 4.
